// File: rtl/modbus_reg_engine.sv
// Modbus register engine: runs one decoded 0x03/0x06 request against RAM
// port B and streams the response payload bytes to the frame builder.
module modbus_reg_engine #(
  parameter int A_WIDTH = 4,
  parameter int MAX_QTY = 125
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               req_valid,
  output logic               req_ready,
  input  logic [7:0]         req_func,
  input  logic [15:0]        req_addr,
  input  logic [15:0]        req_qty,
  input  logic [15:0]        req_wdata,
  output logic               ram_en,
  output logic               ram_we,
  output logic [A_WIDTH-1:0] ram_addr,
  output logic [15:0]        ram_di,
  input  logic [15:0]        ram_do,
  output logic [7:0]         tx_data,
  output logic               tx_valid,
  input  logic               tx_ready,
  output logic               tx_last,
  output logic               tx_exc,
  output logic               done
);

  typedef enum logic [3:0] {
    IDLE, CHECK, WR, ECHO, CNT, RD, RDW, HI, LO, EXC, FIN
  } state_t;

  localparam logic [16:0] LIMIT = 17'(2 ** A_WIDTH);

  state_t state, state_nx;

  logic [7:0]         func;
  logic [15:0]        addr;
  logic [15:0]        qty;
  logic [15:0]        wdata;
  logic [15:0]        hold;
  logic [15:0]        rem;
  logic [7:0]         code;
  logic [A_WIDTH-1:0] cur;
  logic [1:0]         idx;

  logic        is_rd;
  logic        is_wr;
  logic        bad_qty;
  logic [15:0] span;
  logic [16:0] sum;
  logic [7:0]  exc_code;
  logic        xfer;

  assign is_rd   = func == 8'h03;
  assign is_wr   = func == 8'h06;
  assign bad_qty = qty == 16'd0 || qty > 16'(MAX_QTY);
  assign span    = is_rd ? qty : 16'd1;
  assign sum     = {1'b0, addr} + {1'b0, span};
  assign xfer    = tx_valid & tx_ready;

  // Exception priority: illegal function, then bad count, then range.
  always_comb begin
    exc_code = 8'h00;
    if (!is_rd && !is_wr)
      exc_code = 8'h01;
    else if (is_rd && bad_qty)
      exc_code = 8'h03;
    else if (sum > LIMIT)
      exc_code = 8'h02;
  end

  always_ff @(posedge clock) begin
    if (reset)
      state <= IDLE;
    else
      state <= state_nx;
  end

  always_comb begin
    state_nx  = state;
    req_ready = 1'b0;
    ram_en    = 1'b0;
    ram_we    = 1'b0;
    ram_addr  = '0;
    ram_di    = '0;
    tx_data   = 8'h00;
    tx_valid  = 1'b0;
    tx_last   = 1'b0;
    tx_exc    = 1'b0;
    done      = 1'b0;
    unique case (state)
      IDLE: begin
        req_ready = 1'b1;
        if (req_valid)
          state_nx = CHECK;
      end
      CHECK: begin
        if (exc_code != 8'h00)
          state_nx = EXC;
        else if (is_wr)
          state_nx = WR;
        else
          state_nx = CNT;
      end
      WR: begin
        ram_en   = 1'b1;
        ram_we   = 1'b1;
        ram_addr = addr[A_WIDTH-1:0];
        ram_di   = wdata;
        state_nx = ECHO;
      end
      ECHO: begin
        tx_valid = 1'b1;
        tx_last  = idx == 2'd3;
        unique case (idx)
          2'd0: tx_data = addr[15:8];
          2'd1: tx_data = addr[7:0];
          2'd2: tx_data = wdata[15:8];
          2'd3: tx_data = wdata[7:0];
          default: tx_data = 8'h00;
        endcase
        if (xfer && idx == 2'd3)
          state_nx = FIN;
      end
      CNT: begin
        tx_valid = 1'b1;
        tx_data  = {qty[6:0], 1'b0};
        if (xfer)
          state_nx = RD;
      end
      RD: begin
        ram_en   = 1'b1;
        ram_addr = cur;
        state_nx = RDW;
      end
      RDW: state_nx = HI;
      HI: begin
        tx_valid = 1'b1;
        tx_data  = hold[15:8];
        if (xfer)
          state_nx = LO;
      end
      LO: begin
        tx_valid = 1'b1;
        tx_data  = hold[7:0];
        tx_last  = rem == 16'd1;
        if (xfer)
          state_nx = (rem == 16'd1) ? FIN : RD;
      end
      EXC: begin
        tx_valid = 1'b1;
        tx_data  = code;
        tx_exc   = 1'b1;
        tx_last  = 1'b1;
        if (xfer)
          state_nx = FIN;
      end
      FIN: begin
        done     = 1'b1;
        state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      func  <= 8'h00;
      addr  <= 16'h0000;
      qty   <= 16'h0000;
      wdata <= 16'h0000;
      hold  <= 16'h0000;
      rem   <= 16'h0000;
      code  <= 8'h00;
      cur   <= '0;
      idx   <= 2'd0;
    end else begin
      if (state == IDLE && req_valid) begin
        func  <= req_func;
        addr  <= req_addr;
        qty   <= req_qty;
        wdata <= req_wdata;
      end
      if (state == CHECK) begin
        code <= exc_code;
        cur  <= addr[A_WIDTH-1:0];
        rem  <= qty;
        idx  <= 2'd0;
      end
      if (state == RDW)
        hold <= ram_do;
      if (state == ECHO && xfer)
        idx <= idx + 2'd1;
      if (state == LO && xfer) begin
        cur <= cur + A_WIDTH'(1);
        rem <= rem - 16'd1;
      end
    end
  end

endmodule

// File: tb/tb_modbus_reg_engine.sv
// Scoreboard bench for modbus_reg_engine: expected bytes and RAM writes
// are queued by the stimulus and consumed by a negedge monitor.
module tb_modbus_reg_engine;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic [7:0]  req_func = 8'h00;
  logic [15:0] req_addr = 16'h0000;
  logic [15:0] req_qty = 16'h0000;
  logic [15:0] req_wdata = 16'h0000;
  logic        ram_en;
  logic        ram_we;
  logic [3:0]  ram_addr;
  logic [15:0] ram_di;
  logic [15:0] ram_do = 16'h0000;
  logic [7:0]  tx_data;
  logic        tx_valid;
  logic        tx_ready;
  logic        tx_last;
  logic        tx_exc;
  logic        done;

  logic bp = 1'b0;
  logic rnd = 1'b1;
  logic rdy = 1'b1;
  logic load = 1'b0;

  assign tx_ready = bp ? rnd : rdy;

  always #5 clock = ~clock;

  modbus_reg_engine #(.A_WIDTH(4), .MAX_QTY(125)) dut (
    .clock(clock), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_func(req_func), .req_addr(req_addr),
    .req_qty(req_qty), .req_wdata(req_wdata),
    .ram_en(ram_en), .ram_we(ram_we), .ram_addr(ram_addr),
    .ram_di(ram_di), .ram_do(ram_do),
    .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
    .tx_last(tx_last), .tx_exc(tx_exc), .done(done)
  );

  logic [15:0] mem [16];
  logic [15:0] model [16];

  always @(posedge clock) begin
    if (load) begin
      for (int i = 0; i < 16; i++) mem[i] <= model[i];
    end else if (ram_en) begin
      if (ram_we) mem[ram_addr] <= ram_di;
      else ram_do <= mem[ram_addr];
    end
  end

  initial forever begin
    @(posedge clock);
    #1;
    rnd = 1'($urandom_range(0, 1));
  end

  int n_chk = 0;
  int n_fail = 0;
  int nbytes = 0;
  int ndone = 0;
  int nacc = 0;
  int nram = 0;
  logic [9:0]  exp_q [$];
  logic [19:0] wr_q [$];

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  logic       busy = 1'b0;
  logic       stall = 1'b0;
  logic [9:0] pv = 10'h0;

  always @(negedge clock) begin
    if (reset) begin
      busy  = 1'b0;
      stall = 1'b0;
    end else begin
      if (stall) begin
        chk("hold_valid", 32'(tx_valid), 32'(1));
        chk("hold_byte", 32'({tx_exc, tx_last, tx_data}), 32'(pv));
      end
      stall = tx_valid && !tx_ready;
      pv = {tx_exc, tx_last, tx_data};
      if (tx_valid && tx_ready) begin
        nbytes++;
        if (exp_q.size() == 0) begin
          n_chk++;
          n_fail++;
          $display("FAIL tx_byte: got %0h expected none", pv);
        end else begin
          chk("tx_byte", 32'(pv), 32'(exp_q.pop_front()));
        end
      end
      if (ram_en) nram++;
      if (ram_en && ram_we) begin
        if (wr_q.size() == 0) begin
          n_chk++;
          n_fail++;
          $display("FAIL ram_write: got %0h expected none",
                   {ram_addr, ram_di});
        end else begin
          chk("ram_write", 32'({ram_addr, ram_di}), 32'(wr_q.pop_front()));
        end
      end
      if (busy) chk("req_ready_busy", 32'(req_ready), 32'(0));
      if (done) begin
        ndone++;
        chk("done_in_busy", 32'(busy), 32'(1));
        busy = 1'b0;
      end
      if (req_valid && req_ready) begin
        busy = 1'b1;
        nacc++;
      end
    end
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic push_read(input int a, input int q);
    logic [15:0] v;
    logic [15:0] dq;
    dq = 16'(2 * q);
    exp_q.push_back({2'b00, dq[7:0]});
    for (int i = 0; i < q; i++) begin
      v = model[a + i];
      exp_q.push_back({2'b00, v[15:8]});
      exp_q.push_back({1'b0, i == q - 1, v[7:0]});
    end
  endtask

  task automatic push_write(input logic [15:0] a, input logic [15:0] w);
    model[a[3:0]] = w;
    wr_q.push_back({a[3:0], w});
    exp_q.push_back({2'b00, a[15:8]});
    exp_q.push_back({2'b00, a[7:0]});
    exp_q.push_back({2'b00, w[15:8]});
    exp_q.push_back({2'b01, w[7:0]});
  endtask

  task automatic push_exc(input logic [7:0] c);
    exp_q.push_back({2'b11, c});
  endtask

  task automatic issue(input logic [7:0] f, input logic [15:0] a,
                       input logic [15:0] q, input logic [15:0] w);
    int t = 0;
    while (!req_ready && t < 200) begin
      tick();
      t++;
    end
    if (t >= 200) begin
      n_chk++;
      n_fail++;
      $display("FAIL issue_timeout: got busy expected ready");
    end
    req_valid = 1'b1;
    req_func  = f;
    req_addr  = a;
    req_qty   = q;
    req_wdata = w;
    tick();
    req_valid = 1'b0;
  endtask

  task automatic wait_done();
    int t = 0;
    while (!done && t < 600) begin
      tick();
      t++;
    end
    if (t >= 600) begin
      n_chk++;
      n_fail++;
      $display("FAIL done_timeout: got no done expected done");
    end
    tick();
    chk("queue_empty", 32'(exp_q.size()), 32'(0));
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int d0;
    int a0;
    int b0;
    int r0;
    int seen;
    int t;
    for (int i = 0; i < 16; i++) model[i] = 16'(i * 16'h1111) ^ 16'h5A5A;
    model[2] = 16'h1234;
    model[3] = 16'hABCD;
    model[4] = 16'h0001;
    load = 1'b1;
    tick();
    tick();
    load = 1'b0;
    chk("reset_ctl", 32'({req_ready, ram_en, ram_we, tx_valid,
                          tx_last, tx_exc, done}), 32'(7'b1000000));
    chk("reset_data", 32'({ram_addr, ram_di, tx_data}), 32'(0));
    reset = 1'b0;
    tick();

    // Read three registers, with first-byte latency checks.
    d0 = ndone;
    push_read(2, 3);
    issue(8'h03, 16'd2, 16'd3, 16'h0);
    chk("lat_check", 32'(tx_valid), 32'(0));
    tick();
    chk("lat_first", 32'({tx_valid, tx_data}), 32'(9'h106));
    wait_done();
    chk("done_once", 32'(ndone - d0), 32'(1));

    // Write single register, then read it back.
    push_write(16'd5, 16'hBEEF);
    issue(8'h06, 16'd5, 16'd0, 16'hBEEF);
    wait_done();
    push_read(5, 1);
    issue(8'h03, 16'd5, 16'd1, 16'h0);
    wait_done();

    // Exceptions and the top-of-map boundary.
    r0 = nram;
    push_exc(8'h01);
    issue(8'h10, 16'd0, 16'd1, 16'h0);
    wait_done();
    chk("exc_no_ram", 32'(nram - r0), 32'(0));
    push_exc(8'h01);
    issue(8'h04, 16'd0, 16'd0, 16'h0);
    wait_done();
    push_exc(8'h03);
    issue(8'h03, 16'd0, 16'd0, 16'h0);
    wait_done();
    push_exc(8'h03);
    issue(8'h03, 16'd0, 16'd126, 16'h0);
    wait_done();
    push_exc(8'h02);
    issue(8'h03, 16'd14, 16'd3, 16'h0);
    wait_done();
    push_exc(8'h02);
    issue(8'h06, 16'd16, 16'd0, 16'h1111);
    wait_done();
    push_read(15, 1);
    issue(8'h03, 16'd15, 16'd1, 16'h0);
    wait_done();
    chk("ram_cycles", 32'(nram - r0), 32'(1));

    // Random backpressure across a long read.
    bp = 1'b1;
    push_read(0, 8);
    issue(8'h03, 16'd0, 16'd8, 16'h0);
    wait_done();
    bp = 1'b0;

    // Reset while the second register's high byte is offered.
    b0 = nbytes;
    push_read(0, 3);
    issue(8'h03, 16'd0, 16'd3, 16'h0);
    t = 0;
    while (!(nbytes == b0 + 3 && tx_valid) && t < 100) begin
      tick();
      t++;
    end
    chk("reached_hi2", 32'(t < 100), 32'(1));
    rdy = 1'b0;
    reset = 1'b1;
    d0 = ndone;
    tick();
    chk("rst_ready", 32'({req_ready, tx_valid}), 32'(2'b10));
    reset = 1'b0;
    exp_q.delete();
    rdy = 1'b1;
    tick();
    tick();
    chk("rst_no_done", 32'(ndone - d0), 32'(0));
    push_read(3, 2);
    issue(8'h03, 16'd3, 16'd2, 16'h0);
    wait_done();

    // REQ_VALID held high across two back-to-back requests.
    a0 = nacc;
    d0 = ndone;
    push_read(4, 1);
    push_read(4, 1);
    req_func  = 8'h03;
    req_addr  = 16'd4;
    req_qty   = 16'd1;
    req_valid = 1'b1;
    seen = 0;
    t = 0;
    while (seen < 2 && t < 200) begin
      tick();
      t++;
      if (done) seen++;
    end
    req_valid = 1'b0;
    tick();
    tick();
    chk("held_accepts", 32'(nacc - a0), 32'(2));
    chk("held_dones", 32'(ndone - d0), 32'(2));
    chk("held_queue", 32'(exp_q.size()), 32'(0));
    chk("wr_queue", 32'(wr_q.size()), 32'(0));

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/modbus_reg_engine.md
# modbus_reg_engine

Executes one decoded Modbus request against the holding-register RAM and streams the response payload bytes. Sits between the RTU frame receiver/decoder (upstream) and the response frame builder (downstream), and drives port B of the dual-port holding-register RAM. Supports function 0x03 (read holding registers) and 0x06 (write single register) and generates exception codes 0x01/0x02/0x03. Slave address, function byte and CRC are added by the frame builder.

## Interface
- A_WIDTH, 4: RAM address width; register map holds 2**A_WIDTH 16-bit registers.
- MAX_QTY, 125: maximum register count for 0x03.
- CLOCK  in  1  sole clock; RAM port B is clocked by the same CLOCK.
- RESET  in  1  synchronous, active-high reset.
- REQ_VALID  in  1  request fields valid.
- REQ_READY  out  1  engine accepts a request (high only in IDLE).
- REQ_FUNC  in  8  function code.
- REQ_ADDR  in  16  starting register address.
- REQ_QTY  in  16  register count (ignored for 0x06).
- REQ_WDATA  in  16  write value (0x06 only).
- RAM_EN  out  1  RAM port enable.
- RAM_WE  out  1  RAM port write enable.
- RAM_ADDR  out  A_WIDTH  RAM port address.
- RAM_DI  out  16  RAM write data.
- RAM_DO  in  16  RAM read data; valid the cycle after RAM_EN sampled high.
- TX_DATA  out  8  response payload byte.
- TX_VALID  out  1  TX_DATA valid.
- TX_READY  in  1  downstream accepts byte.
- TX_LAST  out  1  current byte is last of response.
- TX_EXC  out  1  response is an exception (set function MSB downstream).
- DONE  out  1  one-cycle pulse after last byte accepted.

## Operation
- States: IDLE, CHECK, WR, ECHO, CNT, RD, RDW, HI, LO, EXC, FIN.
- IDLE: REQ_READY=1. REQ_VALID&REQ_READY latches FUNC/ADDR/QTY/WDATA -> CHECK.
- CHECK (1 cycle), priority order:
  - FUNC not 0x03/0x06 -> EXC code 0x01.
  - 0x03 with QTY==0 or QTY>MAX_QTY -> EXC code 0x03.
  - ADDR+N > 2**A_WIDTH (17-bit sum; N=QTY for 0x03, 1 for 0x06) -> EXC code 0x02.
  - else 0x06 -> WR, 0x03 -> CNT.
- WR (1 cycle): RAM_EN=1, RAM_WE=1, RAM_ADDR=ADDR[A_WIDTH-1:0], RAM_DI=WDATA -> ECHO.
- ECHO: 4 bytes ADDR[15:8], ADDR[7:0], WDATA[15:8], WDATA[7:0]; TX_LAST on 4th; -> FIN after 4th accept.
- CNT: byte = (2*QTY)[7:0]; on accept -> RD. Internal cur=ADDR, rem=QTY.
- RD (1 cycle): RAM_EN=1, RAM_WE=0, RAM_ADDR=cur -> RDW.
- RDW (1 cycle): capture RAM_DO into 16-bit hold register -> HI.
- HI: byte hold[15:8]; on accept -> LO.
- LO: byte hold[7:0]; TX_LAST when rem==1. On accept: rem==1 -> FIN, else cur+1, rem-1 -> RD.
- EXC: single byte = code, TX_EXC=1, TX_LAST=1; on accept -> FIN.
- FIN: DONE=1 one cycle -> IDLE.
- RAM_EN/RAM_WE are 0 in every state not listed above; RAM never written outside WR.

## Timing
- Reset values: state IDLE, REQ_READY=1, RAM_EN=0, RAM_WE=0, RAM_ADDR=0, RAM_DI=0, TX_VALID=0, TX_DATA=0, TX_LAST=0, TX_EXC=0, DONE=0.
- TX handshake: byte transfers on cycle with TX_VALID&TX_READY; while TX_VALID=1 and TX_READY=0, TX_DATA/TX_LAST/TX_EXC held stable.
- First byte valid 2 cycles after request accept (CHECK, then CNT/EXC; for 0x06 WR inserts 1 more cycle).
- 0x03 with TX_READY tied high: 2 cycles per byte pair overhead (RD, RDW) + 2 byte cycles = 4 cycles per register.
- REQ_VALID ignored outside IDLE; new request accepted earliest the cycle after DONE.
- Reset mid-operation: next cycle is IDLE with reset values; partially sent response abandoned, no DONE; no RAM write issued.
- RAM shared with port A (receiver side); same-address collisions are resolved by the RAM, not here.

## Test plan
- RAM[2..4]=0x1234,0xABCD,0x0001; req 0x03 ADDR=2 QTY=3 -> bytes 06,12,34,AB,CD,00,01, TX_LAST on 0x01, DONE once, TX_EXC=0.
- Req 0x06 ADDR=5 WDATA=0xBEEF -> one RAM write addr 5 data 0xBEEF; bytes 00,05,BE,EF; subsequent 0x03 ADDR=5 QTY=1 returns 02,BE,EF.
- Req FUNC=0x10 -> single byte 0x01, TX_EXC=1, TX_LAST=1, no RAM_EN; QTY=0 -> 0x03; A_WIDTH=4 ADDR=14 QTY=3 -> 0x02; ADDR=15 QTY=1 -> normal read.
- Random TX_READY backpressure on 0x03 QTY=8 -> byte sequence identical to no-backpressure run, TX_DATA stable while stalled.
- RESET asserted in HI of second register -> REQ_READY=1, TX_VALID=0 next cycle, no DONE; next request served correctly.
- REQ_VALID held high continuously -> exactly one request accepted per DONE, REQ_READY low from CHECK through FIN.
